// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - mode encoding and seconds constants for the clock controller
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/clock_ctrl_if.sv
// rtl/clock_ctrl_if.sv - tick/button inputs and counter-side outputs of the clock controller
interface clock_ctrl_if;
  import clock_ctrl_pkg::*;

  logic             tick_1hz;
  logic             btn_mode;
  logic             btn_inc;
  logic             min_at_max;
  logic             enable;
  logic             min_inc;
  logic             hr_inc;
  logic [SEC_W-1:0] sec_val;
  logic [1:0]       mode;
  logic             blink;

  modport master (
    input  tick_1hz, btn_mode, btn_inc, min_at_max,
    output enable, min_inc, hr_inc, sec_val, mode, blink
  );

  modport slave (
    output tick_1hz, btn_mode, btn_inc, min_at_max,
    input  enable, min_inc, hr_inc, sec_val, mode, blink
  );

endinterface

// File: rtl/clock_ctrl_btn_sync_edge.sv
// rtl/clock_ctrl_btn_sync_edge.sv - button synchronizer with registered rising-edge pulse
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      level_q <= sync_q[SYNC_STAGES-1];
      rise    <= sync_q[SYNC_STAGES-1] & ~level_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - run/set mode sequencer owning seconds and driving minute/hour increments
// Optional increment auto-repeat while held: CLOCK_CTRL_AUTO_REPEAT_EN
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_S   = 30
`ifdef CLOCK_CTRL_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 2
`endif
) (
  input logic          clk,
  input logic          rst,
  clock_ctrl_if.master bus
);

  mode_t            mode_q, mode_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             min_inc_q, min_inc_d, hr_inc_q, hr_inc_d, enable_q;
  logic             blink_q, blink_d;
  logic [7:0]       to_q, to_d;
  logic             mode_level, mode_rise, inc_level, inc_rise;
  logic             set_mode, btn_event, inc_req, timeout, levels_unused;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_btn (
    .clk(clk), .rst(rst), .raw(bus.btn_mode), .level(mode_level), .rise(mode_rise)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_btn (
    .clk(clk), .rst(rst), .raw(bus.btn_inc), .level(inc_level), .rise(inc_rise)
  );

  assign set_mode = (mode_q == MODE_SET_HR) || (mode_q == MODE_SET_MIN);

`ifdef CLOCK_CTRL_AUTO_REPEAT_EN
  logic [7:0] rep_q, rep_d;
  logic       held_tick;

  // A held button counts as activity, so it also keeps the timeout at bay.
  assign held_tick     = set_mode && inc_level && bus.tick_1hz;
  assign inc_req       = inc_rise || (held_tick && (rep_q >= 8'(REPEAT_DELAY)));
  assign btn_event     = mode_rise || inc_rise || held_tick;
  assign levels_unused = mode_level;

  always_comb begin
    rep_d = rep_q;
    if (!set_mode || !inc_level) begin
      rep_d = '0;
    end else if (bus.tick_1hz && (rep_q < 8'(REPEAT_DELAY))) begin
      rep_d = rep_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end
`else
  assign inc_req       = inc_rise;
  assign btn_event     = mode_rise || inc_rise;
  assign levels_unused = mode_level | inc_level;
`endif

  assign timeout = set_mode && bus.tick_1hz && !btn_event && (to_q == 8'(TIMEOUT_S - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_RUN;
      sec_q     <= '0;
      min_inc_q <= 1'b0;
      hr_inc_q  <= 1'b0;
      enable_q  <= 1'b0;
      blink_q   <= 1'b0;
      to_q      <= '0;
    end else begin
      mode_q    <= mode_d;
      sec_q     <= sec_d;
      min_inc_q <= min_inc_d;
      hr_inc_q  <= hr_inc_d;
      enable_q  <= min_inc_d | hr_inc_d;
      blink_q   <= blink_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:     if (mode_rise) mode_d = MODE_SET_HR;
      MODE_SET_HR:  if (mode_rise) mode_d = MODE_SET_MIN;
                    else if (timeout) mode_d = MODE_RUN;
      MODE_SET_MIN: if (mode_rise || timeout) mode_d = MODE_RUN;
      default:      mode_d = MODE_RUN;
    endcase
  end

  always_comb begin
    sec_d     = sec_q;
    min_inc_d = 1'b0;
    hr_inc_d  = 1'b0;
    blink_d   = blink_q;
    to_d      = to_q;
    case (mode_q)
      MODE_RUN: begin
        to_d    = '0;
        blink_d = 1'b0;
        if (bus.tick_1hz) begin
          if (sec_q == SEC_MAX) begin
            sec_d     = '0;
            min_inc_d = 1'b1;
            hr_inc_d  = bus.min_at_max;
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      MODE_SET_HR, MODE_SET_MIN: begin
        if (btn_event)         to_d = '0;
        else if (bus.tick_1hz) to_d = to_q + 8'd1;
        if (bus.tick_1hz) blink_d = ~blink_q;
        // A mode edge in the same cycle swallows the increment.
        if (inc_req && !mode_rise) begin
          if (mode_q == MODE_SET_HR) hr_inc_d  = 1'b1;
          else                       min_inc_d = 1'b1;
        end
      end
      default: begin
        sec_d   = '0;
        blink_d = 1'b0;
        to_d    = '0;
      end
    endcase
    if (mode_d != mode_q) begin
      blink_d = 1'b0;
      to_d    = '0;
      if (mode_d == MODE_RUN) sec_d = '0;
    end
  end

  assign bus.sec_val = sec_q;
  assign bus.mode    = mode_q;
  assign bus.min_inc = min_inc_q;
  assign bus.hr_inc  = hr_inc_q;
  assign bus.enable  = enable_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl against a behavioural model
module tb_clock_ctrl;
  import clock_ctrl_pkg::*;

  localparam int S  = 2;
  localparam int TO = 30;
  localparam bit H  = 1'b1;
  localparam bit L  = 1'b0;

  typedef struct {
    int n_ticks;
    bit mam;
    int sec;
    bit min_inc;
    bit hr_inc;
    bit enable;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_ctrl_if bus ();
  clock_ctrl #(.SYNC_STAGES(S), .TIMEOUT_S(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   n_min  = 0;
  int   n_hr   = 0;
  bit   mode_at[int];
  bit   inc_at[int];
  bit   prev_bm, prev_bi, rbm, rbi, hit;
  int   m_mode, m_sec, m_to;
  bit   m_min, m_hr, m_blink;
  vec_t vecs[7];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  function automatic int obs();
    return int'({bus.mode, bus.sec_val, bus.min_inc, bus.hr_inc, bus.enable, bus.blink});
  endfunction

  function automatic int model_obs();
    logic [1:0] md;
    logic [5:0] sc;
    md = m_mode[1:0];
    sc = m_sec[5:0];
    return int'({md, sc, m_min, m_hr, m_min | m_hr, m_blink});
  endfunction

  // Reference: one clock edge worth of behaviour given the events that reach the controller.
  function automatic void model_step(input bit tk, input bit mev, input bit iev, input bit mam);
    int nmode;
    nmode = m_mode;
    m_min = 1'b0;
    m_hr  = 1'b0;
    if (m_mode == 0) begin
      if (tk) begin
        if (m_sec == 59) begin
          m_min = 1'b1;
          m_hr  = mam;
        end
        m_sec = (m_sec + 1) % 60;
      end
      if (mev) nmode = 1;
    end else if (mev) begin
      nmode = (m_mode == 1) ? 2 : 0;
    end else begin
      if (iev) begin
        if (m_mode == 1) m_hr = 1'b1;
        else             m_min = 1'b1;
        m_to = 0;
      end else if (tk) begin
        m_to = m_to + 1;
      end
      if (tk) m_blink = !m_blink;
      if (m_to == TO) nmode = 0;
    end
    if (nmode != m_mode) begin
      m_blink = 1'b0;
      m_to    = 0;
      if (nmode == 0) m_sec = 0;
    end
    m_mode = nmode;
  endfunction

  function automatic void model_clear();
    m_mode = 0; m_sec = 0; m_to = 0;
    m_min = 1'b0; m_hr = 1'b0; m_blink = 1'b0;
    mode_at.delete();
    inc_at.delete();
    prev_bm = 1'b0;
    prev_bi = 1'b0;
  endfunction

  task automatic step(input bit tk, input bit bm, input bit bi, input bit mam);
    bus.tick_1hz   = tk;
    bus.btn_mode   = bm;
    bus.btn_inc    = bi;
    bus.min_at_max = mam;
    if (bm && !prev_bm) mode_at[cyc + S + 2] = 1'b1;
    if (bi && !prev_bi) inc_at[cyc + S + 2] = 1'b1;
    prev_bm = bm;
    prev_bi = bi;
    @(posedge clk);
    cyc++;
    model_step(tk, mode_at.exists(cyc) != 0, inc_at.exists(cyc) != 0, mam);
    #1;
    if (bus.min_inc) n_min++;
    if (bus.hr_inc)  n_hr++;
    chk("outputs_vs_model", obs(), model_obs());
  endtask

  task automatic press(input bit bm, input bit bi, input bit mam, input bit want_pulse,
                       input string name);
    int seen;
    seen = -1;
    for (int k = 1; k <= S + 3; k++) begin
      step(L, bm, bi, mam);
      if ((bus.min_inc || bus.hr_inc) && seen < 0) seen = k;
    end
    chk(name, seen, want_pulse ? S + 2 : -1);
    repeat (S + 3) step(L, L, L, mam);
  endtask

  task automatic ticks(input int n, input bit mam);
    for (int k = 0; k < n; k++) begin
      step(H, L, L, mam);
      step(L, L, L, mam);
    end
  endtask

  task automatic do_reset();
    bus.tick_1hz   = 1'b0;
    bus.btn_mode   = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.min_at_max = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_values", obs(), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected under 1000000", $time);
    $fatal(1);
  end

  initial begin
    // Cumulative tick runs from reset: {ticks, min_at_max, sec, min_inc, hr_inc, enable}
    vecs[0] = '{1,  L, 1,  L, L, L};
    vecs[1] = '{57, L, 58, L, L, L};
    vecs[2] = '{1,  L, 59, L, L, L};
    vecs[3] = '{1,  L, 0,  H, L, H};
    vecs[4] = '{59, H, 59, L, L, L};
    vecs[5] = '{1,  H, 0,  H, H, H};
    vecs[6] = '{1,  H, 1,  L, L, L};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      for (int k = 1; k <= vecs[i].n_ticks; k++) begin
        step(H, L, L, vecs[i].mam);
        if (k < vecs[i].n_ticks) step(L, L, L, vecs[i].mam);
      end
      chk($sformatf("vec%0d", i),
          int'({bus.sec_val, bus.min_inc, bus.hr_inc, bus.enable}),
          int'({6'(vecs[i].sec), vecs[i].min_inc, vecs[i].hr_inc, vecs[i].enable}));
      step(L, L, L, vecs[i].mam);
      if (i == 3) begin
        chk("one_min_inc_per_minute", n_min, 1);
        chk("no_hr_inc_in_minute", n_hr, 0);
      end
    end

    press(H, L, L, L, "enter_set_hr");
    chk("mode_set_hr", int'(bus.mode), 1);
    n_hr = 0;
    for (int p = 0; p < 3; p++) press(L, H, L, H, $sformatf("hr_press%0d_latency", p));
    chk("three_hr_inc", n_hr, 3);
    ticks(5, L);
    chk("sec_frozen_in_set", int'(bus.sec_val), 1);

    press(H, L, H, L, "enter_set_min");
    chk("mode_set_min", int'(bus.mode), 2);
    n_min = 0;
    n_hr  = 0;
    press(L, H, H, H, "min_press_latency");
    chk("min_inc_once", n_min, 1);
    chk("no_carry_into_hr", n_hr, 0);
    press(H, L, H, L, "exit_set_min");
    chk("run_sec_cleared", int'({bus.mode, bus.sec_val}), 0);

    press(H, L, L, L, "enter_set_hr_timeout");
    ticks(TO - 1, L);
    chk("timeout_not_yet", int'(bus.mode), 1);
    chk("blink_on_before_timeout", int'(bus.blink), 1);
    step(H, L, L, L);
    chk("timeout_mode_run", int'(bus.mode), 0);
    chk("timeout_blink_off", int'(bus.blink), 0);

    press(H, L, L, L, "enter_set_hr_simul");
    press(H, H, L, L, "simul_inc_dropped");
    chk("simul_mode_advanced", int'(bus.mode), 2);
    press(H, L, L, L, "exit_simul");

    ticks(17, L);
    press(H, L, L, L, "mp_enter_set_hr");
    press(H, L, L, L, "mp_enter_set_min");
    chk("mp_sec_17", int'(bus.sec_val), 17);
    hit = 1'b0;
    for (int k = 0; k < S + 3 && !hit; k++) begin
      step(L, L, H, L);
      hit = bus.min_inc;
    end
    chk("mp_pulse_seen", int'(hit), 1);
    rst = 1'b0;
    #1;
    chk("mp_reset_aborts_pulse", obs(), 0);
    do_reset();

    rbm = 1'b0;
    rbi = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 63) == 0) rbm = !rbm;
      if ($urandom_range(0, 47) == 0) rbi = !rbi;
      step(bit'($urandom_range(0, 1)), rbm, rbi, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
